// File: rtl/adder_fault_locator.sv
// -----------------------------------------------------------------------------
// adder_fault_locator
//   Self-test engine for a WIDTH-bit ripple-carry adder under test. It drives
//   every operand combination (or the first NUM_VEC of them) onto dut_a/dut_b/
//   dut_cin. Each vector is held for SETTLE cycles, and dut_sum is sampled on
//   one further cycle. Each sample is compared against an internal golden
//   A+B+CIN. The block accumulates the failing-vector count and an OR of all
//   difference patterns. It localises the faulty stage as the lowest
//   mismatching bit of the first failing vector.
//
// Ports
//   clk             in   1          clock, rising edge
//   rst_n           in   1          asynchronous active-low reset
//   start           in   1          one-cycle pulse, begins a run from IDLE
//   dut_a           out  WIDTH      operand A to the adder under test
//   dut_b           out  WIDTH      operand B to the adder under test
//   dut_cin         out  1          carry-in to the adder under test
//   dut_sum         in   WIDTH+1    sum returned by the adder under test
//   busy            out  1          run in progress
//   done            out  1          run complete, held until the next start
//   fault_found     out  1          at least one mismatch in the run
//   fault_bit       out  4          lowest differing bit of the first failure
//   first_fail_idx  out  2*WIDTH+1  vector index of the first failure
//   mismatch_mask   out  WIDTH+1    OR of all difference patterns of the run
//   err_count       out  16         failing-vector count, saturating
// -----------------------------------------------------------------------------
module adder_fault_locator #(
  parameter int WIDTH   = 8,
  parameter int NUM_VEC = 2 ** (2 * WIDTH + 1),
  parameter int SETTLE  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH:0]       dut_sum,
  output logic                 busy,
  output logic                 done,
  output logic                 fault_found,
  output logic [3:0]           fault_bit,
  output logic [2*WIDTH:0]     first_fail_idx,
  output logic [WIDTH:0]       mismatch_mask,
  output logic [15:0]          err_count
);

  localparam int IDX_W = 2 * WIDTH + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Position of the lowest set bit; scanning downwards lets the lowest hit win.
  function automatic logic [3:0] lowest_set_bit(input logic [WIDTH:0] vec);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (vec[i] == 1'b1) begin
        pos = 4'(i);
      end
    end
    return pos;
  endfunction

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_fault_found;
  logic [3:0]         r_fault_bit;
  logic [IDX_W-1:0]   r_first_fail_idx;
  logic [WIDTH:0]     r_mask;
  logic [15:0]        r_err_count;

  logic [WIDTH:0]     w_golden;
  logic [WIDTH:0]     w_diff;
  logic               w_mismatch;
  logic [3:0]         w_low_bit;

  // The vector index is the operand register itself: cin, then B, then A.
  assign dut_cin = r_idx[0];
  assign dut_b   = r_idx[WIDTH:1];
  assign dut_a   = r_idx[2*WIDTH:WIDTH+1];

  // Golden sum is carried to WIDTH+1 bits so the carry-out is checked too.
  assign w_golden   = {1'b0, r_idx[2*WIDTH:WIDTH+1]} + {1'b0, r_idx[WIDTH:1]}
                    + {{WIDTH{1'b0}}, r_idx[0]};
  assign w_diff     = dut_sum ^ w_golden;
  // Case inequality makes an X/Z sum bit count as a failure.
  assign w_mismatch = (dut_sum !== w_golden);
  assign w_low_bit  = lowest_set_bit(w_diff);

  assign busy           = r_busy;
  assign done           = r_done;
  assign fault_found    = r_fault_found;
  assign fault_bit      = r_fault_bit;
  assign first_fail_idx = r_first_fail_idx;
  assign mismatch_mask  = r_mask;
  assign err_count      = r_err_count;

  // Run sequencer: apply/settle, sample and accumulate, then report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_idx            <= '0;
      r_cnt            <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_fault_found    <= 1'b0;
      r_fault_bit      <= 4'd0;
      r_first_fail_idx <= '0;
      r_mask           <= '0;
      r_err_count      <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state          <= S_APPLY;
            r_idx            <= '0;
            r_cnt            <= '0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_fault_found    <= 1'b0;
            r_fault_bit      <= 4'd0;
            r_first_fail_idx <= '0;
            r_mask           <= '0;
            r_err_count      <= 16'd0;
          end
        end

        S_APPLY: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != 16'hFFFF) begin
              r_err_count <= r_err_count + 16'd1;
            end
            r_mask <= r_mask | w_diff;
            // Only the first failing vector localises the fault.
            if (!r_fault_found) begin
              r_fault_found    <= 1'b1;
              r_fault_bit      <= w_low_bit;
              r_first_fail_idx <= r_idx;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_APPLY;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_fault_locator.sv
module tb_adder_fault_locator;

  localparam int W   = 4;
  localparam int IW  = 2 * W + 1;
  localparam int NV  = 2 ** IW;
  localparam int ST  = 2;
  localparam int RUN = NV * (ST + 1) + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  dut_a;
  logic [W-1:0]  dut_b;
  logic          dut_cin;
  logic [W:0]    dut_sum;
  logic          busy;
  logic          done;
  logic          fault_found;
  logic [3:0]    fault_bit;
  logic [IW-1:0] first_fail_idx;
  logic [W:0]    mismatch_mask;
  logic [15:0]   err_count;

  int fmode;
  int fk;
  int cyc;
  int n_vec;
  int n_miss;
  logic done_q;

  typedef struct {
    logic          ff;
    logic [3:0]    fb;
    logic [IW-1:0] ffi;
    logic [W:0]    mask;
    logic [15:0]   ec;
    int            done_cyc;
  } exp_t;

  exp_t sbq[$];

  adder_fault_locator #(.WIDTH(W), .NUM_VEC(NV), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin), .dut_sum(dut_sum),
    .busy(busy), .done(done), .fault_found(fault_found), .fault_bit(fault_bit),
    .first_fail_idx(first_fail_idx), .mismatch_mask(mismatch_mask),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test with one injectable fault:
  // 1 stage k sum ignores carry-in, 2 sum[k] stuck-0, 3 sum[k] stuck-1,
  // 4 carry-out of stage k stuck-0.
  function automatic logic [W:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input int mode, input int k);
    logic [W:0] s;
    logic c;
    logic co;
    c = cin;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      if (mode == 1 && i == k) s[i] = a[i] ^ b[i];
      co = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      if (mode == 4 && i == k) co = 1'b0;
      c = co;
    end
    s[W] = c;
    if (mode == 2) s[k] = 1'b0;
    if (mode == 3) s[k] = 1'b1;
    return s;
  endfunction

  assign dut_sum = adder_model(dut_a, dut_b, dut_cin, fmode, fk);

  // Reference: walk every vector with plain integer arithmetic.
  function automatic exp_t build_expect(input int mode, input int k);
    exp_t e;
    int a, b, ci, gold, diff;
    logic [W:0] got;
    e.ff = 1'b0; e.fb = 4'd0; e.ffi = '0; e.mask = '0; e.ec = 16'd0; e.done_cyc = 0;
    for (int idx = 0; idx < NV; idx++) begin
      ci = idx % 2;
      b = (idx / 2) % (2 ** W);
      a = idx / (2 ** (W + 1));
      gold = a + b + ci;
      got = adder_model(W'(a), W'(b), ci[0], mode, k);
      diff = int'(got) ^ gold;
      if (diff != 0) begin
        if (e.ec != 16'hFFFF) e.ec = e.ec + 16'd1;
        e.mask = e.mask | (W+1)'(diff);
        if (!e.ff) begin
          e.ff = 1'b1;
          e.ffi = IW'(idx);
          for (int j = W; j >= 0; j--) if (diff[j]) e.fb = 4'(j);
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each rising done, pop the oldest expectation and compare.
  initial begin
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: got done=1 expected no pending run");
        end else begin
          e = sbq.pop_front();
          check("done_latency", cyc, e.done_cyc);
          check("fault_found", {31'd0, fault_found}, {31'd0, e.ff});
          check("fault_bit", {28'd0, fault_bit}, {28'd0, e.fb});
          check("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
          check("mismatch_mask", 32'(mismatch_mask), 32'(e.mask));
          check("err_count", {16'd0, err_count}, {16'd0, e.ec});
        end
      end
      done_q = done;
    end
  end

  // poke: 0 none, 1 start pulse at vector 5, 2 start pulse on the DONE cycle
  task automatic run_vectors(input int mode, input int k, input int poke);
    exp_t e;
    int acc;
    @(negedge clk);
    fmode = mode;
    fk = k;
    e = build_expect(mode, k);
    acc = cyc + 1;
    e.done_cyc = acc + RUN;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    for (int i = 0; i < RUN + 8 && done !== 1'b1; i++) begin
      @(negedge clk);
      start = ((poke == 1 && cyc == acc + 16) || (poke == 2 && cyc == e.done_cyc - 1)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_held", {31'd0, done}, 32'd1);
  endtask

  task automatic abort_run(input int mode, input int k);
    int acc;
    @(negedge clk);
    fmode = mode;
    fk = k;
    acc = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < RUN && cyc < acc + 31; i++) @(negedge clk);
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ff", {31'd0, fault_found}, 32'd0);
    check("abort_fb", {28'd0, fault_bit}, 32'd0);
    check("abort_ffi", 32'(first_fail_idx), 32'd0);
    check("abort_mask", 32'(mismatch_mask), 32'd0);
    check("abort_ec", {16'd0, err_count}, 32'd0);
    check("abort_vec", {23'd0, dut_a, dut_b, dut_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int mode, k;
    n_vec = 0;
    n_miss = 0;
    cyc = 0;
    fmode = 0;
    fk = 0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ff", {31'd0, fault_found}, 32'd0);
    check("rst_ec", {16'd0, err_count}, 32'd0);
    check("rst_vec", {23'd0, dut_a, dut_b, dut_cin}, 32'd0);
    rst_n = 1'b1;

    run_vectors(0, 0, 0);      // fault-free
    run_vectors(1, 2, 1);      // stage 2 drops carry-in, start pulsed mid-run
    run_vectors(2, W, 2);      // carry-out stuck-0, start pulsed on DONE cycle
    run_vectors(3, 0, 0);      // LSB stuck-1
    abort_run(3, 0);
    run_vectors(3, 0, 0);      // rerun after abort must match a clean run
    run_vectors(4, 1, 0);      // carry chain broken at stage 1

    for (int r = 0; r < 8; r++) begin
      mode = int'($urandom_range(0, 4));
      k = (mode == 2 || mode == 3) ? int'($urandom_range(0, W)) : int'($urandom_range(0, W - 1));
      run_vectors(mode, k, 0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #(2000000);
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
